alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Two-stage pipelined, parametrised-width ALU with valid/ready handshakes on both sides, registered result and flags, and an accumulator-forwarding mode.
- Same 16-opcode set as the existing combinational ALU.
- Adds backpressure, sticky carry/overflow status and chained ops on the previous result, for the datapath ahead of the CDC synchronizers.
- Accepts one op per cycle at full throughput.

Parameters:
- N, 8, operand/result width; must be ≥2 and a power of two. SH = $clog2(N).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  block can accept an op this cycle
- in_a  in  N  operand a
- in_b  in  N  operand b
- in_op  in  4  opcode
- in_use_acc  in  1  replace a with accumulator value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  N  result
- out_zero, out_carry, out_overflow, out_sign, out_equal  out  1 each  flags for out_data
- sticky_carry, sticky_overflow  out  1 each  OR of all carry/overflow flags since last clear
- clr_sticky  in  1  clear sticky flags
- acc  out  N  accumulator value

Behaviour:
- Reset (async on rst_n low, sync release): all outputs 0, including stage valids, acc and sticky flags. in_ready = 1 on the first cycle after reset. An op in flight at reset is discarded.
- Stage 1 (S1) registers a, b, op and use_acc on in_valid && in_ready.
- Compute between S1 and S2 is combinational:
  - ea = use_acc ? acc : a.
  - Registered into S2 (out_data + flags) when S1 is valid and S2 is empty or out_ready is high.
- in_ready = !s1_valid || s1_advance. Fully pipelined, no bubbles.
- Latency: op accepted in cycle t gives out_valid in cycle t+2.
- With out_ready=0 the block holds 2 ops, then in_ready=0. Outputs stay stable while out_valid && !out_ready. No loss, no duplication, order preserved.
- Opcodes, where sa = b[SH-1:0]:
  - 0 ADD; 1 SUB (ea + ~b + 1); 2 NAND; 3 NOR; 4 AND; 5 OR; 6 XOR; 7 NOT ea.
  - 8 SLL by sa; 9 SRL by sa; A ROL by sa; B ROR by sa; C SRA by sa.
  - D SLT signed; E SLTU. Both return {N-1 zeros, bit}.
  - F NOP: passes ea.
- Flags:
  - zero = (result == 0).
  - sign = result[N-1].
  - equal = (ea == b).
  - carry = adder carry-out, for ADD and SUB only. For SUB, carry=1 means no borrow (ea ≥ b unsigned).
  - overflow = two's-complement overflow, for ADD and SUB only.
  - carry and overflow are 0 for all other ops.
- Accumulator:
  - acc is loaded with the computed result on the S1→S2 transfer, for every op except F.
  - Ops are strictly ordered, so an op with use_acc always sees the result of the most recent non-NOP op, even back-to-back.
- Sticky flags:
  - On the S1→S2 transfer, sticky |= carry/overflow.
  - clr_sticky clears both.
  - Same-cycle clear and set: set wins, so the flag ends at 1.

Decomposition:
- Package alu_pkg: opcode enum alu_op_e (16 values above) and a flags struct (zero, carry, overflow, sign, equal).
- Sub-module alu_exec: purely combinational compute (ea, b, op → result, flags), parametrised by N.
- alu_pipe holds the handshake, pipeline registers, acc and sticky logic.

Test Plan:
- N=8, ADD a=0x7F b=0x01 issued at t, out_ready=1: out_valid at t+2 with data 0x80, overflow=1, sign=1, carry=0, zero=0; sticky_overflow=1 afterwards.
- SUB a=0x03 b=0x05: data 0xFE, carry=0, sign=1, equal=0. Then SUB a=0x05 b=0x05: data 0x00, zero=1, equal=1, carry=1.
- Back-to-back ADD 5+3, then in_use_acc=1 ADD b=10, then in_use_acc=1 SLL b=1: results 0x08, 0x12, 0x24 on consecutive cycles, acc=0x24.
- Hold out_ready=0 while driving 4 ops: only 2 accepted, in_ready=0, out_data stable. Release out_ready: all 4 results emerge in order, none lost or repeated.
- ROR a=0x81 b=0x09 (sa=1): 0xC0. SRA a=0x80 b=3: 0xF0. SLT a=0xFF b=0x01: 0x01. SLTU a=0xFF b=0x01: 0x00.
- rst_n low mid-stream with 2 ops in flight: all outputs and sticky flags 0 immediately. After release no stale result appears and in_ready=1. clr_sticky on the same cycle as an overflowing ADD transfer leaves sticky_overflow=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and result-flag bundle for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NAND = 4'h2,
    OP_NOR  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOT  = 4'h7,
    OP_SLL  = 4'h8,
    OP_SRL  = 4'h9,
    OP_ROL  = 4'hA,
    OP_ROR  = 4'hB,
    OP_SRA  = 4'hC,
    OP_SLT  = 4'hD,
    OP_SLTU = 4'hE,
    OP_NOP  = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic sign;
    logic equal;
  } alu_flags_t;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU core: one result and one flag set per (ea, b, op).
module alu_exec
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] ea_i,
  input  logic [N-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [N-1:0] result_o,
  output alu_flags_t   flags_o
);

  localparam int SH = $clog2(N);

  // N is a power of two, so SH-bit index arithmetic wraps exactly like a rotate.
  function automatic logic [N-1:0] rot_r(input logic [N-1:0] v, input logic [SH-1:0] amt);
    logic [N-1:0]  r;
    logic [SH-1:0] k;
    r = '0;
    for (int i = 0; i < N; i++) begin
      k    = SH'(i) + amt;
      r[i] = v[k];
    end
    return r;
  endfunction

  logic [SH-1:0] sa;
  logic [SH-1:0] neg_sa;
  logic          is_sub;
  logic [N-1:0]  b_eff;
  logic [N:0]    sum;
  logic          arith;

  always_comb begin
    sa     = b_i[SH-1:0];
    neg_sa = ~sa + 1'b1;
    is_sub = (op_i == OP_SUB);
    b_eff  = is_sub ? ~b_i : b_i;
    sum    = {1'b0, ea_i} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    arith  = (op_i == OP_ADD) || is_sub;

    result_o = '0;
    unique case (op_i)
      OP_ADD, OP_SUB: result_o = sum[N-1:0];
      OP_NAND:        result_o = ~(ea_i & b_i);
      OP_NOR:         result_o = ~(ea_i | b_i);
      OP_AND:         result_o = ea_i & b_i;
      OP_OR:          result_o = ea_i | b_i;
      OP_XOR:         result_o = ea_i ^ b_i;
      OP_NOT:         result_o = ~ea_i;
      OP_SLL:         result_o = ea_i << sa;
      OP_SRL:         result_o = ea_i >> sa;
      OP_ROL:         result_o = rot_r(ea_i, neg_sa);
      OP_ROR:         result_o = rot_r(ea_i, sa);
      OP_SRA:         result_o = $unsigned($signed(ea_i) >>> sa);
      OP_SLT:         result_o = {{(N-1){1'b0}}, ($signed(ea_i) < $signed(b_i))};
      OP_SLTU:        result_o = {{(N-1){1'b0}}, (ea_i < b_i)};
      OP_NOP:         result_o = ea_i;
      default:        result_o = '0;
    endcase

    flags_o.zero     = (result_o == '0);
    flags_o.sign     = result_o[N-1];
    flags_o.equal    = (ea_i == b_i);
    flags_o.carry    = arith & sum[N];
    flags_o.overflow = arith & (ea_i[N-1] == b_eff[N-1]) & (sum[N-1] != ea_i[N-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: S1 operand register, S2 result/flag register,
// accumulator forwarding and sticky carry/overflow status.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [3:0]   in_op,
  input  logic         in_use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_zero,
  output logic         out_carry,
  output logic         out_overflow,
  output logic         out_sign,
  output logic         out_equal,
  output logic         sticky_carry,
  output logic         sticky_overflow,
  input  logic         clr_sticky,
  output logic [N-1:0] acc
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // valid never depends on ready; ready may depend on the downstream ready.
  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_a_q, s1_a_d;
  logic [N-1:0] s1_b_q, s1_b_d;
  alu_op_e      s1_op_q, s1_op_d;
  logic         s1_use_acc_q, s1_use_acc_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  alu_flags_t   out_flags_q, out_flags_d;
  logic [N-1:0] acc_q, acc_d;
  logic         sticky_c_q, sticky_c_d;
  logic         sticky_v_q, sticky_v_d;

  logic         s1_advance;
  logic         in_fire;
  logic [N-1:0] ea;
  logic [N-1:0] exec_res;
  alu_flags_t   exec_flags;

  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;
  // acc is written on the very edge S1 advances, so a chained op in S1 already sees it.
  assign ea         = s1_use_acc_q ? acc_q : s1_a_q;

  alu_exec #(.N(N)) u_exec (
    .ea_i    (ea),
    .b_i     (s1_b_q),
    .op_i    (s1_op_q),
    .result_o(exec_res),
    .flags_o (exec_flags)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_op_d      = s1_op_q;
    s1_use_acc_d = s1_use_acc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_flags_d  = out_flags_q;
    acc_d        = acc_q;
    sticky_c_d   = clr_sticky ? 1'b0 : sticky_c_q;
    sticky_v_d   = clr_sticky ? 1'b0 : sticky_v_q;

    if (s1_advance) s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_valid_d   = 1'b1;
      s1_a_d       = in_a;
      s1_b_d       = in_b;
      s1_op_d      = alu_op_e'(in_op);
      s1_use_acc_d = in_use_acc;
    end

    if (out_ready) out_valid_d = 1'b0;
    if (s1_advance) begin
      out_valid_d = 1'b1;
      out_data_d  = exec_res;
      out_flags_d = exec_flags;
      if (s1_op_q != OP_NOP) acc_d = exec_res;
      sticky_c_d  = sticky_c_d | exec_flags.carry;
      sticky_v_d  = sticky_v_d | exec_flags.overflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= OP_ADD;
      s1_use_acc_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_flags_q  <= '0;
      acc_q        <= '0;
      sticky_c_q   <= 1'b0;
      sticky_v_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s1_use_acc_q <= s1_use_acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
      acc_q        <= acc_d;
      sticky_c_q   <= sticky_c_d;
      sticky_v_q   <= sticky_v_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_zero        = out_flags_q.zero;
  assign out_carry       = out_flags_q.carry;
  assign out_overflow    = out_flags_q.overflow;
  assign out_sign        = out_flags_q.sign;
  assign out_equal       = out_flags_q.equal;
  assign sticky_carry    = sticky_c_q;
  assign sticky_overflow = sticky_v_q;
  assign acc             = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (N=8): latency, flags, chaining, backpressure,
// shifts/compares, mid-stream reset and sticky clear/set collision.
module tb_alu_pipe;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [3:0]   in_op;
  logic         in_use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_zero, out_carry, out_overflow, out_sign, out_equal;
  logic         sticky_carry, sticky_overflow;
  logic         clr_sticky;
  logic [N-1:0] acc;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  alu_pipe #(.N(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_op          (in_op),
    .in_use_acc     (in_use_acc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_zero       (out_zero),
    .out_carry      (out_carry),
    .out_overflow   (out_overflow),
    .out_sign       (out_sign),
    .out_equal      (out_equal),
    .sticky_carry   (sticky_carry),
    .sticky_overflow(sticky_overflow),
    .clr_sticky     (clr_sticky),
    .acc            (acc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Issue one op into an empty pipe with out_ready=1; checks the 2-cycle latency.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic ua, input logic [N-1:0] exp_d);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_use_acc = ua;
    tick();
    chk1({tag, "_lat"}, out_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    chk1({tag, "_vld"}, out_valid, 1'b1);
    chk8({tag, "_data"}, out_data, exp_d);
  endtask

  initial begin
    int sent;
    int got;
    logic [N-1:0] exp_v;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_use_acc = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_out_data", out_data, 8'h00);
    chk8("rst_acc", acc, 8'h00);
    chk1("rst_sticky_ov", sticky_overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk1("rst_in_ready", in_ready, 1'b1);

    // ADD overflow into sign bit
    run_op("add_ovf", 4'h0, 8'h7F, 8'h01, 1'b0, 8'h80);
    chk1("add_ovf_ov", out_overflow, 1'b1);
    chk1("add_ovf_sign", out_sign, 1'b1);
    chk1("add_ovf_carry", out_carry, 1'b0);
    chk1("add_ovf_zero", out_zero, 1'b0);
    chk1("add_ovf_sticky_ov", sticky_overflow, 1'b1);
    chk1("add_ovf_sticky_c", sticky_carry, 1'b0);

    // SUB with borrow, then equal operands
    run_op("sub_borrow", 4'h1, 8'h03, 8'h05, 1'b0, 8'hFE);
    chk1("sub_borrow_carry", out_carry, 1'b0);
    chk1("sub_borrow_sign", out_sign, 1'b1);
    chk1("sub_borrow_equal", out_equal, 1'b0);
    run_op("sub_eq", 4'h1, 8'h05, 8'h05, 1'b0, 8'h00);
    chk1("sub_eq_zero", out_zero, 1'b1);
    chk1("sub_eq_equal", out_equal, 1'b1);
    chk1("sub_eq_carry", out_carry, 1'b1);
    chk1("sub_eq_sticky_c", sticky_carry, 1'b1);
    tick();

    // back-to-back accumulator chaining
    in_valid = 1'b1; in_op = 4'h0; in_a = 8'h05; in_b = 8'h03; in_use_acc = 1'b0;
    tick();
    chk1("chain_lat", out_valid, 1'b0);
    in_op = 4'h0; in_a = 8'hEE; in_b = 8'h0A; in_use_acc = 1'b1;
    tick();
    chk8("chain_r0", out_data, 8'h08);
    chk8("chain_acc0", acc, 8'h08);
    in_op = 4'h8; in_a = 8'hEE; in_b = 8'h01; in_use_acc = 1'b1;
    tick();
    chk1("chain_v1", out_valid, 1'b1);
    chk8("chain_r1", out_data, 8'h12);
    in_valid = 1'b0; in_use_acc = 1'b0;
    tick();
    chk1("chain_v2", out_valid, 1'b1);
    chk8("chain_r2", out_data, 8'h24);
    chk8("chain_acc2", acc, 8'h24);
    tick();
    chk1("chain_drained", out_valid, 1'b0);

    // backpressure: 4 ops, downstream stalled for the first 6 cycles
    out_ready = 1'b0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 6) out_ready = 1'b1;
      in_valid = (sent < 4); in_op = 4'h0; in_b = 8'h00; in_use_acc = 1'b0;
      in_a = 8'(8'h11 * (sent + 1));
      #1;
      if (cyc >= 2 && cyc <= 5) chk8("bp_hold_data", out_data, 8'h11);
      if (cyc == 5) begin
        chk32("bp_accepted", sent, 2);
        chk1("bp_in_ready", in_ready, 1'b0);
        chk1("bp_out_valid", out_valid, 1'b1);
      end
      if (out_valid && out_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk8("bp_order", out_data, exp_v);
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_a);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk32("bp_count", got, 4);
    chk32("bp_queue_left", exp_q.size(), 0);
    chk1("bp_drained", out_valid, 1'b0);

    // rotates, arithmetic shift, compares
    run_op("ror", 4'hB, 8'h81, 8'h09, 1'b0, 8'hC0);
    run_op("rol", 4'hA, 8'h81, 8'h02, 1'b0, 8'h06);
    run_op("sra", 4'hC, 8'h80, 8'h03, 1'b0, 8'hF0);
    run_op("slt", 4'hD, 8'hFF, 8'h01, 1'b0, 8'h01);
    run_op("sltu", 4'hE, 8'hFF, 8'h01, 1'b0, 8'h00);
    chk1("sltu_carry", out_carry, 1'b0);
    run_op("nand", 4'h2, 8'hF0, 8'h3C, 1'b0, 8'hCF);
    run_op("nop", 4'hF, 8'h5A, 8'h00, 1'b0, 8'h5A);
    chk8("nop_acc_kept", acc, 8'hCF);
    tick();

    // reset with two ops in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'h0; in_a = 8'h7F; in_b = 8'h01; in_use_acc = 1'b0;
    tick();
    in_a = 8'h10;
    tick();
    chk1("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk8("arst_out_data", out_data, 8'h00);
    chk8("arst_acc", acc, 8'h00);
    chk1("arst_sticky_ov", sticky_overflow, 1'b0);
    chk1("arst_sticky_c", sticky_carry, 1'b0);
    chk1("arst_ov", out_overflow, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_no_stale0", out_valid, 1'b0);
    tick();
    chk1("post_rst_no_stale1", out_valid, 1'b0);

    // clear and set of sticky on the same edge: set wins
    in_valid = 1'b1; in_op = 4'h0; in_a = 8'h7F; in_b = 8'h01;
    tick();
    in_valid = 1'b0; clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk1("clr_set_valid", out_valid, 1'b1);
    chk1("clr_set_sticky_ov", sticky_overflow, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk1("clr_only_sticky_ov", sticky_overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
